// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: bus widths and the owner encoding
// used to steer synchronous read data back to the requester that was granted.
package core_pkg;

    localparam int CORE_AW = 8;
    localparam int CORE_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high
// reset. MAX_VAL sets the ceiling so the same block serves both the fetch
// starvation streak and the fetch-stall statistic.
module sat_counter #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over increment; once at the ceiling the value holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter for the single-port memory shared by instruction fetch and the
// load/store unit. Data accesses normally win; after MAX_STREAK consecutive
// data wins against a waiting fetch the fetch is forced through. Read data
// returns one cycle after the grant and is steered by the owner register.
module imem_dmem_arbiter
    import core_pkg::*;
#(
    parameter int AW         = CORE_AW,
    parameter int DW         = CORE_DW,
    parameter int MAX_STREAK = 3,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_en,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,

    output logic [CW-1:0] stall_cnt
);

    localparam int            SW         = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic          w_fetchOk;
    logic          w_forceIf;
    logic          w_dGnt;
    logic          w_ifGnt;
    logic [SW-1:0] w_streak;
    owner_t        r_owner;

    // A fetch is only eligible when it is not being flushed; it is forced
    // through once data has won MAX_STREAK times in a row against it.
    assign w_fetchOk = if_req & ~if_flush;
    assign w_forceIf = w_fetchOk & (w_streak == STREAK_MAX);
    assign w_dGnt    = d_req & ~w_forceIf;
    assign w_ifGnt   = w_fetchOk & ~w_dGnt;

    assign d_gnt  = w_dGnt;
    assign if_gnt = w_ifGnt;

    // Steer the granted requester onto the memory port; idle port drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        if (w_dGnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wr    = d_we;
            mem_en    = 1'b1;
        end else if (w_ifGnt) begin
            mem_addr  = if_addr;
            mem_en    = 1'b1;
        end
    end

    // Remember who issued a read this cycle so next cycle's data goes back to them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else if (w_ifGnt) begin
            r_owner <= OWN_IF;
        end else if (w_dGnt && !d_we) begin
            r_owner <= OWN_D;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    // A flush arriving while the fetch data returns kills that response only.
    assign if_rvalid = (r_owner == OWN_IF) & ~if_flush;
    assign d_rvalid  = (r_owner == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    sat_counter #(
        .WIDTH   (SW),
        .MAX_VAL (STREAK_MAX)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_dGnt & w_fetchOk),
        .clear (w_ifGnt | ~w_fetchOk),
        .count (w_streak)
    );

    sat_counter #(
        .WIDTH   (CW),
        .MAX_VAL ({CW{1'b1}})
    ) u_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_req & ~w_ifGnt),
        .clear (1'b0),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter with a behavioural memory and a
// reference model built from the arbitration rules (losses counted as an
// integer, memory contents kept in a plain array).
module tb_imem_dmem_arbiter;

    localparam int MAX_STREAK = 3;
    localparam int CW         = 4;
    localparam int STALL_TOP  = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [7:0]    if_addr;
    logic          if_flush;
    logic          if_gnt;
    logic          if_rvalid;
    logic [7:0]    if_rdata;
    logic          d_req;
    logic          d_we;
    logic [7:0]    d_addr;
    logic [7:0]    d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [7:0]    d_rdata;
    logic [7:0]    mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_en;
    logic          mem_wr;
    logic [7:0]    mem_rdata;
    logic [CW-1:0] stall_cnt;

    int errCount;
    int checkCount;

    logic [7:0] refMem [256];
    int         fetchLosses;
    int         expStall;
    bit         pendIf;
    logic [7:0] pendIfData;
    bit         pendD;
    logic [7:0] pendDData;

    imem_dmem_arbiter #(
        .AW         (8),
        .DW         (8),
        .MAX_STREAK (MAX_STREAK),
        .CW         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .stall_cnt (stall_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous memory standing in for the real mem instance.
    initial begin
        logic [7:0] memArr [256];
        for (int i = 0; i < 256; i++) memArr[i] = 8'hA0 + 8'(i);
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_wr) memArr[mem_addr] = mem_wdata;
                else        mem_rdata <= memArr[mem_addr];
            end
        end
    end

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Forget all in-flight state, as a reset does.
    task automatic modelReset();
        fetchLosses = 0;
        expStall    = 0;
        pendIf      = 1'b0;
        pendD       = 1'b0;
    endtask

    // Drive one cycle of requests, check everything at the falling edge, advance the model.
    task automatic applyStimulus(input bit ifReq, input logic [7:0] ifAddr, input bit ifFlush,
                                 input bit dReq, input bit dWe, input logic [7:0] dAddr,
                                 input logic [7:0] dWdata);
        bit         fetchOk;
        bit         expD;
        bit         expI;
        logic [7:0] expAddr;
        if_req   = ifReq;
        if_addr  = ifAddr;
        if_flush = ifFlush;
        d_req    = dReq;
        d_we     = dWe;
        d_addr   = dAddr;
        d_wdata  = dWdata;
        @(negedge clk);
        fetchOk = ifReq && !ifFlush;
        expD    = dReq && !(fetchOk && fetchLosses >= MAX_STREAK);
        expI    = fetchOk && !expD;
        expAddr = expD ? dAddr : (expI ? ifAddr : 8'h00);
        checkOutput("d_gnt", 32'(d_gnt), 32'(expD));
        checkOutput("if_gnt", 32'(if_gnt), 32'(expI));
        checkOutput("mem_en", 32'(mem_en), 32'(expD || expI));
        checkOutput("mem_wr", 32'(mem_wr), 32'(expD && dWe));
        checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(expD ? dWdata : 8'h00));
        checkOutput("if_rvalid", 32'(if_rvalid), 32'(pendIf && !ifFlush));
        if (pendIf && !ifFlush) checkOutput("if_rdata", 32'(if_rdata), 32'(pendIfData));
        checkOutput("d_rvalid", 32'(d_rvalid), 32'(pendD));
        if (pendD) checkOutput("d_rdata", 32'(d_rdata), 32'(pendDData));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(expStall));
        pendIf     = expI;
        pendIfData = refMem[ifAddr];
        pendD      = expD && !dWe;
        pendDData  = refMem[dAddr];
        if (expD && dWe) refMem[dAddr] = dWdata;
        if (expD && fetchOk) fetchLosses = fetchLosses + 1;
        else                 fetchLosses = 0;
        if (ifReq && !expI && expStall < STALL_TOP) expStall = expStall + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Directed scenarios first, then a randomized stream against the model.
    initial begin
        errCount   = 0;
        checkCount = 0;
        for (int i = 0; i < 256; i++) refMem[i] = 8'hA0 + 8'(i);
        modelReset();
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 8'h00;
        if_flush = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 8'h00;
        d_wdata  = 8'h00;

        @(negedge clk);
        checkOutput("reset_if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("reset_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("reset_stall", 32'(stall_cnt), 32'd0);
        checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] fetch-only stream");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idleCycle();

        $display("[TB] store then load");
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h10, 8'h5C);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        checkOutput("store_load_rdata", 32'(d_rdata), 32'h5C);
        idleCycle();

        $display("[TB] starvation pattern");
        pulseReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 8'(8'h20 + 8'(i)), 8'h00);
        idleCycle();
        checkOutput("starve_stall", 32'(stall_cnt), 32'd6);

        $display("[TB] flush");
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 8'h31, 8'h00);
        idleCycle();

        $display("[TB] async reset after load grant");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        checkOutput("pre_reset_d_rvalid", 32'(d_rvalid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("async_stall", 32'(stall_cnt), 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idleCycle();
        idleCycle();

        $display("[TB] stall saturation");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 8'h40, 8'(i));
        idleCycle();
        checkOutput("stall_saturated", 32'(stall_cnt), 32'(STALL_TOP));

        $display("[TB] randomized traffic");
        pulseReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 31)),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 9) < 4), 8'($urandom_range(0, 31)),
                          8'($urandom));
            if (($urandom_range(0, 99)) == 0) pulseReset();
        end
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
